fetch_controller: RTL and testbench

Sequencing controller for the ARM instruction-fetch stage when instruction memory has variable latency. Owns the fetch PC, runs a req/ready handshake to the instruction memory, and holds or drops fetched words on hazard stalls and taken branches. Presents one registered instruction/PC pair plus valid to the IF/ID register, and emits a one-cycle flush pulse for the downstream pipeline registers.

---
 rtl/fetch_controller_if.sv | 28 ++
 rtl/fetch_controller.sv | 97 +++++++++
 tb/tb_fetch_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Instruction-fetch bus: hazard/branch inputs, instruction-memory handshake and IF/ID delivery.
// The master side is the fetch controller.
interface fetch_controller_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               hazard;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_address;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc_out;
    logic               if_valid;
    logic               flush;

    modport master (
        input  hazard, branch_taken, branch_address, imem_ready, imem_rdata,
        output imem_req, imem_addr, instruction, pc_out, if_valid, flush
    );

    modport slave (
        output hazard, branch_taken, branch_address, imem_ready, imem_rdata,
        input  imem_req, imem_addr, instruction, pc_out, if_valid, flush
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the PC, runs the req/ready handshake to variable-latency
// instruction memory, and holds or drops fetched words on hazards and taken branches.
module fetch_controller #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  drop_addr;
    logic [INSTR_W-1:0] skid;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_out_q;
    logic               valid_q;
    logic               flush_q;
    logic [ADDR_W-1:0]  pc_inc;

    assign pc_inc          = pc + ADDR_W'(4);
    assign bus.imem_req    = (state == REQ) || (state == DROP);
    assign bus.imem_addr   = (state == DROP) ? drop_addr : pc;
    assign bus.instruction = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.if_valid    = valid_q;
    assign bus.flush       = flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            drop_addr <= '0;
            skid      <= '0;
            instr_q   <= '0;
            pc_out_q  <= '0;
            valid_q   <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            flush_q <= bus.branch_taken;
            if (bus.branch_taken) begin
                pc      <= bus.branch_address;
                valid_q <= 1'b0;
                case (state)
                    REQ: begin
                        if (!bus.imem_ready) begin
                            drop_addr <= pc;
                            state     <= DROP;
                        end
                    end
                    // A completing stale request must not be reissued, so DROP only persists while it is still pending.
                    DROP: begin
                        if (bus.imem_ready) begin
                            state <= REQ;
                        end
                    end
                    default: state <= REQ;
                endcase
            end else begin
                case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (bus.imem_ready) begin
                            pc <= pc_inc;
                            if (bus.hazard) begin
                                skid  <= bus.imem_rdata;
                                state <= HOLD;
                            end else begin
                                instr_q  <= bus.imem_rdata;
                                pc_out_q <= pc_inc;
                                valid_q  <= 1'b1;
                            end
                        end else if (!bus.hazard) begin
                            valid_q <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!bus.hazard) begin
                            instr_q  <= skid;
                            pc_out_q <= pc;
                            valid_q  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                    DROP: begin
                        valid_q <= 1'b0;
                        if (bus.imem_ready) begin
                            state <= REQ;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, multi-cycle corner sequences,
// and random traffic against a transaction-level reference model.
module tb_fetch_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_controller_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    fetch_controller #(.ADDR_W(32), .INSTR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          hz;
        bit          br;
        logic [31:0] ba;
        bit          rdy;
        logic [31:0] rd;
        bit          e_req;
        bit          chk_addr;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcout;
        bit          e_flush;
    } vec_t;

    vec_t tbl[$];

    // reference model: fetch progress seen as outstanding transaction + held words
    bit          model_on = 1'b0;
    bit          m_started, m_discard, m_valid, m_flush;
    logic [31:0] m_pc, m_req_addr, m_instr, m_pcout;
    logic [31:0] m_held[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hE3A0_5000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_discard = 0; m_valid = 0; m_flush = 0;
        m_pc = 0; m_req_addr = 0; m_instr = 0; m_pcout = 0;
        m_held.delete();
    endtask

    task automatic model_step();
        logic [31:0] w;
        m_flush = bus.branch_taken;
        if (!m_started) begin
            m_started = 1;
            if (bus.branch_taken) begin m_pc = bus.branch_address; m_valid = 0; end
            m_req_addr = m_pc;
        end else if (m_held.size() != 0) begin
            if (bus.branch_taken) begin
                m_held.delete();
                m_pc = bus.branch_address; m_valid = 0; m_req_addr = m_pc;
            end else if (!bus.hazard) begin
                w = m_held.pop_front();
                m_instr = w; m_pcout = m_pc; m_valid = 1; m_req_addr = m_pc;
            end
        end else if (m_discard) begin
            m_valid = 0;
            if (bus.branch_taken) m_pc = bus.branch_address;
            if (bus.imem_ready) begin m_discard = 0; m_req_addr = m_pc; end
        end else if (bus.branch_taken) begin
            m_pc = bus.branch_address; m_valid = 0;
            if (bus.imem_ready) m_req_addr = m_pc; else m_discard = 1;
        end else if (bus.imem_ready) begin
            if (bus.hazard) begin
                m_held.push_back(bus.imem_rdata);
                m_pc = m_pc + 32'd4;
            end else begin
                m_instr = bus.imem_rdata;
                m_pc = m_pc + 32'd4;
                m_pcout = m_pc; m_valid = 1;
                m_req_addr = m_pc;
            end
        end else if (!bus.hazard) begin
            m_valid = 0;
        end
    endtask

    task automatic model_compare(input string tag);
        bit e_req;
        e_req = m_started && (m_held.size() == 0);
        chk({tag, " imem_req"}, 32'(bus.imem_req), 32'(e_req));
        if (e_req) chk({tag, " imem_addr"}, bus.imem_addr, m_req_addr);
        chk({tag, " if_valid"}, 32'(bus.if_valid), 32'(m_valid));
        chk({tag, " flush"}, 32'(bus.flush), 32'(m_flush));
        chk({tag, " instruction"}, bus.instruction, m_instr);
        chk({tag, " pc_out"}, bus.pc_out, m_pcout);
    endtask

    task automatic drive(input bit hz, input bit br, input logic [31:0] ba,
                         input bit rdy, input logic [31:0] rd);
        bus.hazard = hz; bus.branch_taken = br; bus.branch_address = ba;
        bus.imem_ready = rdy; bus.imem_rdata = rd;
    endtask

    task automatic step();
        if (model_on) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " imem_req"}, 32'(bus.imem_req), 0);
        chk({tag, " imem_addr"}, bus.imem_addr, 0);
        chk({tag, " if_valid"}, 32'(bus.if_valid), 0);
        chk({tag, " flush"}, 32'(bus.flush), 0);
        chk({tag, " instruction"}, bus.instruction, 0);
        chk({tag, " pc_out"}, bus.pc_out, 0);
    endtask

    task automatic add(input bit hz, input bit br, input logic [31:0] ba, input bit rdy,
                       input logic [31:0] rd, input bit req, input bit ca, input logic [31:0] addr,
                       input bit v, input logic [31:0] ins, input logic [31:0] pco, input bit fl);
        tbl.push_back('{hz, br, ba, rdy, rd, req, ca, addr, v, ins, pco, fl});
    endtask

    initial begin
        //   hz br ba         rdy rd            req ca addr       v  instr         pc_out     fl
        add(0, 0, 0,          1, 0,              1, 1, 32'h0,     0, 0,            32'h0,     0);
        add(0, 0, 0,          1, word(32'h0),    1, 1, 32'h4,     1, word(32'h0),  32'h4,     0);
        add(0, 0, 0,          1, word(32'h4),    1, 1, 32'h8,     1, word(32'h4),  32'h8,     0);
        add(1, 0, 0,          1, word(32'h8),    0, 0, 0,         1, word(32'h4),  32'h8,     0);
        add(1, 0, 0,          1, 32'hDEAD_BEEF,  0, 0, 0,         1, word(32'h4),  32'h8,     0);
        add(0, 0, 0,          1, 32'hDEAD_BEEF,  1, 1, 32'hC,     1, word(32'h8),  32'hC,     0);
        add(0, 0, 0,          0, 0,              1, 1, 32'hC,     0, word(32'h8),  32'hC,     0);
        add(0, 0, 0,          1, word(32'hC),    1, 1, 32'h10,    1, word(32'hC),  32'h10,    0);
        add(0, 1, 32'h40,     0, 0,              1, 1, 32'h10,    0, word(32'hC),  32'h10,    1);
        add(0, 0, 0,          0, 0,              1, 1, 32'h10,    0, word(32'hC),  32'h10,    0);
        add(0, 0, 0,          1, word(32'h10),   1, 1, 32'h40,    0, word(32'hC),  32'h10,    0);
        add(0, 0, 0,          1, word(32'h40),   1, 1, 32'h44,    1, word(32'h40), 32'h44,    0);
        add(1, 0, 0,          1, word(32'h44),   0, 0, 0,         1, word(32'h40), 32'h44,    0);
        add(1, 1, 32'h80,     0, 0,              1, 1, 32'h80,    0, word(32'h40), 32'h44,    1);
        add(0, 0, 0,          0, 0,              1, 1, 32'h80,    0, word(32'h40), 32'h44,    0);
        add(0, 0, 0,          1, word(32'h80),   1, 1, 32'h84,    1, word(32'h80), 32'h84,    0);
        add(0, 1, 32'h100,    1, word(32'h84),   1, 1, 32'h100,   0, word(32'h80), 32'h84,    1);
        add(0, 1, 32'h200,    1, word(32'h100),  1, 1, 32'h200,   0, word(32'h80), 32'h84,    1);
        add(0, 0, 0,          1, word(32'h200),  1, 1, 32'h204,   1, word(32'h200),32'h204,   0);

        do_reset();
        check_all_zero("reset");
        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].hz, tbl[i].br, tbl[i].ba, tbl[i].rdy, tbl[i].rd);
            step();
            chk({t, " imem_req"}, 32'(bus.imem_req), 32'(tbl[i].e_req));
            if (tbl[i].chk_addr) chk({t, " imem_addr"}, bus.imem_addr, tbl[i].e_addr);
            chk({t, " if_valid"}, 32'(bus.if_valid), 32'(tbl[i].e_valid));
            chk({t, " instruction"}, bus.instruction, tbl[i].e_instr);
            chk({t, " pc_out"}, bus.pc_out, tbl[i].e_pcout);
            chk({t, " flush"}, 32'(bus.flush), 32'(tbl[i].e_flush));
        end

        // PC wraps modulo 2^32
        do_reset();
        drive(0, 0, 0, 1, 0); step();
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'h1111_1111); step();
        chk("wrap target addr", bus.imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 32'h2222_2222); step();
        chk("wrap pc_out", bus.pc_out, 32'h0);
        chk("wrap instruction", bus.instruction, 32'h2222_2222);
        chk("wrap next addr", bus.imem_addr, 32'h0);

        // asynchronous reset in the middle of a dropped request
        do_reset();
        drive(0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 1, word(32'h0)); step();
        drive(0, 1, 32'h300, 0, 0); step();
        chk("drop addr", bus.imem_addr, 32'h4);
        chk("drop flush", 32'(bus.flush), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async rst");
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(0, 0, 0, 1, 0); step();
        chk("restart addr", bus.imem_addr, 32'h0);
        chk("restart req", 32'(bus.imem_req), 1);
        drive(0, 0, 0, 1, word(32'h0)); step();
        chk("restart pc_out", bus.pc_out, 32'h4);
        chk("restart valid", 32'(bus.if_valid), 1);

        // model-checked: ready every third cycle, then random traffic
        do_reset();
        model_on = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 0, (i % 3) == 2, $urandom);
            step();
            model_compare("wait");
        end
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, $urandom);
            step();
            model_compare("rand");
        end
        model_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
